sum_accumulator: RTL and testbench

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

---
 rtl/sum_acc_pkg.sv | 16 +
 rtl/sum_acc_ctrl.sv | 76 +++++++
 rtl/sum_accumulator.sv | 68 ++++++
 tb/tb_sum_accumulator.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sum_acc_pkg.sv
// Shared types and default sizing for the sum accumulator slice.
// The SUM_ACC_SATURATE_EN macro (see sum_accumulator.sv) does not affect this package.
package sum_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int N_SAMPLES_DEF = 4;
    localparam int ACC_W_DEF     = 16;
    localparam int OPERAND_W     = 9;
    localparam int CNT_W         = 8;

endpackage

// File: rtl/sum_acc_ctrl.sv
// Frame controller: IDLE/ACCUM/DONE sequencing, sample counter and handshake.
// Emits acc_upd on every accepted sample and acc_clr on release or abort.
module sum_acc_ctrl
    import sum_acc_pkg::*;
#(
    parameter int N_SAMPLES = N_SAMPLES_DEF
)
(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic in_valid,
    input  logic out_ready,
    output logic in_ready,
    output logic out_valid,
    output logic acc_upd,
    output logic acc_clr
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             release_frame;

    // An abort overrides any handshake completing on the same edge.
    assign accept        = in_valid && in_ready && !clear;
    assign release_frame = out_valid && out_ready && !clear;
    assign acc_upd       = accept;
    assign acc_clr       = clear || release_frame;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state     <= IDLE;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt   <= CNT_W'(1);
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST_CNT) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // in_ready stays low on the release edge; next frame starts a cycle later.
                    if (release_frame) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/sum_accumulator.sv
// Sums N_SAMPLES 9-bit adder results ({C_out,S}) per frame with sticky overflow.
// Define SUM_ACC_SATURATE_EN to clamp the total at 2^ACC_W-1 instead of wrapping.
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int N_SAMPLES = N_SAMPLES_DEF,
    parameter int ACC_W     = ACC_W_DEF
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       S,
    input  logic             C_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] SUM,
    output logic             OVF
);

    logic             acc_upd;
    logic             acc_clr;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic [ACC_W:0]   operand;
    logic [ACC_W:0]   sum_ext;
    logic [ACC_W-1:0] acc_next;

    sum_acc_ctrl #(
        .N_SAMPLES (N_SAMPLES)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .acc_upd   (acc_upd),
        .acc_clr   (acc_clr)
    );

    // One extra bit of headroom exposes the carry that signals overflow.
    assign operand = {{(ACC_W + 1 - OPERAND_W){1'b0}}, C_out, S};
    assign sum_ext = {1'b0, acc} + operand;

`ifdef SUM_ACC_SATURATE_EN
    assign acc_next = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    assign acc_next = sum_ext[ACC_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst || acc_clr) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (acc_upd) begin
            acc <= acc_next;
            ovf <= ovf | sum_ext[ACC_W];
        end
    end

    assign SUM = acc;
    assign OVF = ovf;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: a 16-bit and a 10-bit instance share stimulus,
// expected frame totals are queued on the last sample and compared when out_valid rises.
module tb_sum_accumulator;

    localparam int N = 4;
`ifdef SUM_ACC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        clear;
    logic        in_valid;
    logic        out_ready;
    logic        C_out;
    logic [7:0]  S;
    logic        in_ready16, out_valid16, ovf16;
    logic [15:0] sum16;
    logic        in_ready10, out_valid10, ovf10;
    logic [9:0]  sum10;

    sum_accumulator #(.N_SAMPLES(N), .ACC_W(16)) u_dut16 (
        .clk (clk), .rst (rst), .clear (clear), .in_valid (in_valid), .in_ready (in_ready16),
        .S (S), .C_out (C_out), .out_valid (out_valid16), .out_ready (out_ready),
        .SUM (sum16), .OVF (ovf16)
    );

    sum_accumulator #(.N_SAMPLES(N), .ACC_W(10)) u_dut10 (
        .clk (clk), .rst (rst), .clear (clear), .in_valid (in_valid), .in_ready (in_ready10),
        .S (S), .C_out (C_out), .out_valid (out_valid10), .out_ready (out_ready),
        .SUM (sum10), .OVF (ovf10)
    );

    typedef struct packed {
        logic [15:0] sum16;
        logic        ovf16;
        logic [9:0]  sum10;
        logic        ovf10;
    } exp_t;

    exp_t   sb[$];
    exp_t   last;
    int     n_vec = 0;
    int     n_err = 0;
    int     m_cnt;
    longint m_acc16, m_acc10;
    bit     m_ovf16, m_ovf10, m_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference add: true sum, flag anything above the width, then wrap or clamp.
    function automatic void model_add(inout longint acc, inout bit ovf, input longint op, input longint maxv);
        longint t;
        t = acc + op;
        if (t > maxv) begin
            ovf = 1'b1;
            acc = SAT ? maxv : (t & maxv);
        end else begin
            acc = t;
        end
    endfunction

    task automatic modelReset();
        m_cnt   = 0;
        m_acc16 = 0;
        m_acc10 = 0;
        m_ovf16 = 1'b0;
        m_ovf10 = 1'b0;
        m_done  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [8:0] op, input logic valid);
        bit acc_now;
        {C_out, S} = op;
        in_valid   = valid;
        acc_now    = valid && !m_done && !clear && !rst;
        tick();
        if (acc_now) begin
            model_add(m_acc16, m_ovf16, longint'(op), 64'd65535);
            model_add(m_acc10, m_ovf10, longint'(op), 64'd1023);
            m_cnt++;
            if (m_cnt == N) begin
                sb.push_back('{sum16: m_acc16[15:0], ovf16: m_ovf16, sum10: m_acc10[9:0], ovf10: m_ovf10});
                m_done = 1'b1;
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        chk({tag, "_valid16"}, out_valid16, 1);
        chk({tag, "_valid10"}, out_valid10, 1);
        chk({tag, "_inready"}, in_ready16, 0);
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $error("[TB] FAIL %s_sb: observed no queued frame expected one", tag);
        end else begin
            last = sb.pop_front();
            chk({tag, "_sum16"}, sum16, last.sum16);
            chk({tag, "_ovf16"}, ovf16, last.ovf16);
            chk({tag, "_sum10"}, sum10, last.sum10);
            chk({tag, "_ovf10"}, ovf10, last.ovf10);
        end
    endtask

    task automatic releaseFrame(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        modelReset();
        chk({tag, "_rel_valid"}, out_valid16, 0);
        chk({tag, "_rel_inready"}, in_ready16, 1);
    endtask

    initial begin
        int pat[7] = '{1, 0, 0, 1, 0, 1, 1};
        rst       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        {C_out, S} = 9'h000;
        modelReset();
        tick();
        tick();
        rst = 1'b0;
        $display("[TB] reset released");

        chk("rst_valid", out_valid16, 0);
        chk("rst_inready", in_ready16, 1);
        chk("rst_sum16", sum16, 0);
        chk("rst_ovf16", ovf16, 0);
        chk("rst_sum10", sum10, 0);

        // Back-to-back 0x1FF with out_ready held high: 16-bit fits, 10-bit overflows.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(9'h1FF, 1'b1);
        chk("lat_early", out_valid16, 0);
        applyStimulus(9'h1FF, 1'b1);
        in_valid = 1'b0;
        checkOutput("f1");
        tick();
        modelReset();
        chk("f1_idle_valid", out_valid16, 0);
        chk("f1_idle_inready", in_ready16, 1);
        out_ready = 1'b0;

        // Downstream stall with upstream still offering data.
        for (int i = 0; i < 4; i++) applyStimulus(9'h055, 1'b1);
        checkOutput("f2");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(9'h0AA, 1'b1);
            chk("stall_inready", in_ready16, 0);
            chk("stall_valid", out_valid16, 1);
            chk("stall_sum16", sum16, last.sum16);
            chk("stall_ovf10", ovf10, last.ovf10);
        end
        releaseFrame("f2");
        for (int i = 0; i < 4; i++) applyStimulus(9'h0AA, 1'b1);
        in_valid = 1'b0;
        checkOutput("f3");
        releaseFrame("f3");

        // Reset mid-frame.
        applyStimulus(9'h1FF, 1'b1);
        applyStimulus(9'h1FF, 1'b1);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        modelReset();
        chk("midrst_sum16", sum16, 0);
        chk("midrst_sum10", sum10, 0);
        chk("midrst_inready", in_ready16, 1);
        chk("midrst_valid", out_valid16, 0);
        for (int i = 0; i < 4; i++) applyStimulus(9'h001, 1'b1);
        in_valid = 1'b0;
        checkOutput("f4");
        releaseFrame("f4");

        // Clear coincident with an accept.
        applyStimulus(9'h010, 1'b1);
        applyStimulus(9'h010, 1'b1);
        clear = 1'b1;
        applyStimulus(9'h010, 1'b1);
        clear    = 1'b0;
        in_valid = 1'b0;
        modelReset();
        chk("clr_sum16", sum16, 0);
        chk("clr_inready", in_ready16, 1);
        chk("clr_valid", out_valid16, 0);
        for (int i = 0; i < 4; i++) applyStimulus(9'h010, 1'b1);
        in_valid = 1'b0;
        checkOutput("f5");
        releaseFrame("f5");

        // Gaps leave the running total untouched.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(9'h100, pat[i] != 0);
            if (i == 2) chk("gap_sum16", sum16, 16'h0100);
        end
        in_valid = 1'b0;
        checkOutput("f6");
        releaseFrame("f6");

        // Reset while a frame is waiting in DONE.
        for (int i = 0; i < 4; i++) applyStimulus(9'h1FF, 1'b1);
        in_valid = 1'b0;
        checkOutput("f7");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        modelReset();
        chk("donerst_valid", out_valid16, 0);
        chk("donerst_ovf10", ovf10, 0);
        chk("donerst_sum16", sum16, 0);
        chk("donerst_inready", in_ready16, 1);

        // Clear wins over a same-cycle release.
        for (int i = 0; i < 4; i++) applyStimulus(9'h0FF, 1'b1);
        in_valid = 1'b0;
        checkOutput("f8");
        clear     = 1'b1;
        out_ready = 1'b1;
        tick();
        clear     = 1'b0;
        out_ready = 1'b0;
        modelReset();
        chk("doneclr_valid", out_valid16, 0);
        chk("doneclr_sum16", sum16, 0);
        chk("doneclr_inready", in_ready16, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
